// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - operation codes presented by the execute stage on op_i
//   - FSM state encoding used by hilo_muldiv_ctrl
//   - default datapath width and the last iteration index
//   - helper that classifies signed operations
// -----------------------------------------------------------------------------
package hilo_pkg;

   localparam int unsigned HILO_WIDTH = 32;
   localparam int unsigned ITER_LAST  = HILO_WIDTH - 1;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      WB   = 3'd4
   } state_e;

   function automatic logic op_is_signed(input op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage : hilo_pkg

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Radix-2 iterative engine shared by multiply and divide, one bit per cycle.
//   Multiply : shift-add. acc = {partial_hi, multiplier}; the multiplicand is
//              added into the upper half when acc[0] is set, then the whole
//              accumulator shifts right. After WIDTH steps acc = product.
//   Divide   : restoring division. acc = {remainder, dividend/quotient}; each
//              step shifts left and subtracts the divisor when it fits. After
//              WIDTH steps acc = {remainder, quotient}.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load_i        initialise accumulator/operand/counter for a new operation
//   is_div_i      mode for the operation being loaded (1 = divide)
//   step_i        perform one iteration
//   a_i, b_i      magnitudes: multiplicand/multiplier or dividend/divisor
//   acc_o         2*WIDTH accumulator
//   last_o        the current step is the final iteration
// -----------------------------------------------------------------------------
module muldiv_iter
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH = HILO_WIDTH,
   parameter int unsigned LAST  = ITER_LAST
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic                 is_div_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic [2*WIDTH-1:0]   acc_o,
   output logic                 last_o
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q;
   logic               is_div_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [WIDTH-1:0]   hi_w, lo_w;
   logic [WIDTH:0]     sum_w, rem_sh_w, diff_w;
   logic [2*WIDTH-1:0] mul_next_w, div_next_w;

   assign hi_w = acc_q[2*WIDTH-1:WIDTH];
   assign lo_w = acc_q[WIDTH-1:0];

   // Multiply step: conditional add keeps its carry, which shifts into the top.
   assign sum_w      = {1'b0, hi_w} + ({(WIDTH+1){lo_w[0]}} & {1'b0, opnd_q});
   assign mul_next_w = {sum_w, lo_w[WIDTH-1:1]};

   // Divide step: a borrow out of the trial subtract means "restore".
   assign rem_sh_w   = {hi_w, lo_w[WIDTH-1]};
   assign diff_w     = rem_sh_w - {1'b0, opnd_q};
   assign div_next_w = diff_w[WIDTH] ? {rem_sh_w[WIDTH-1:0], lo_w[WIDTH-2:0], 1'b0}
                                     : {diff_w[WIDTH-1:0],   lo_w[WIDTH-2:0], 1'b1};

   assign acc_d  = is_div_q ? div_next_w : mul_next_w;
   assign acc_o  = acc_q;
   assign last_o = (cnt_q == CNT_W'(LAST));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         cnt_q    <= '0;
      end else if (load_i) begin
         acc_q    <= {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
         opnd_q   <= is_div_i ? b_i : a_i;
         is_div_q <= is_div_i;
         cnt_q    <= '0;
      end else if (step_i) begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_q + 1'b1;
      end
   end

endmodule : muldiv_iter

// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
// HI/LO sequencer: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute, runs the
// iterative engine, fixes up signs and emits one active-low write strobe that
// carries both HI and LO.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start_i, op_i          request valid / operation code (sampled in IDLE)
//   rs_i, rt_i             operands; rs_i is also the MTHI/MTLO source
//   hi_cur_i, lo_cur_i     current HI/LO (preserved half for MTLO/MTHI)
//   flush_i                abort an in-flight operation without writing
//   busy_o                 pipeline stall request
//   hilo_we_o              HI/LO write strobe, active low
//   hi_o, lo_o             write data, held between strobes
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH     = HILO_WIDTH,
   parameter bit          DIV0_FAST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   input  logic [WIDTH-1:0] hi_cur_i,
   input  logic [WIDTH-1:0] lo_cur_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             hilo_we_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_e             state_q, state_d;
   logic               sign_q, sign_d;     // product / quotient sign
   logic               rsign_q, rsign_d;   // remainder sign (dividend sign)
   logic               div0_q, div0_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   rs_q, rs_d;         // raw dividend for divide-by-zero
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   op_e                op_w;
   logic               sa_w, sb_w, op_div_w, rt_zero_w;
   logic [WIDTH-1:0]   a_abs_w, b_abs_w;
   logic               iter_load, iter_step, iter_last;
   logic [2*WIDTH-1:0] acc_w, prod_fix_w;
   logic [WIDTH-1:0]   quot_fix_w, rem_fix_w;

   assign op_w      = op_e'(op_i);
   assign sa_w      = op_is_signed(op_w) & rs_i[WIDTH-1];
   assign sb_w      = op_is_signed(op_w) & rt_i[WIDTH-1];
   assign a_abs_w   = sa_w ? -rs_i : rs_i;
   assign b_abs_w   = sb_w ? -rt_i : rt_i;
   assign op_div_w  = (op_w == OP_DIV) || (op_w == OP_DIVU);
   assign rt_zero_w = (rt_i == '0);

   muldiv_iter #(
      .WIDTH (WIDTH),
      .LAST  (WIDTH - 1)
   ) u_iter (
      .clk      (clk),
      .rst      (rst),
      .load_i   (iter_load),
      .is_div_i (op_div_w),
      .step_i   (iter_step),
      .a_i      (a_abs_w),
      .b_i      (b_abs_w),
      .acc_o    (acc_w),
      .last_o   (iter_last)
   );

   // Sign fix-up. Negating the magnitude of 0x80000000 wraps to itself, which
   // gives the expected 0x80000000 / -1 result without a special case.
   assign prod_fix_w = sign_q  ? -acc_w : acc_w;
   assign quot_fix_w = sign_q  ? -acc_w[WIDTH-1:0] : acc_w[WIDTH-1:0];
   assign rem_fix_w  = rsign_q ? -acc_w[2*WIDTH-1:WIDTH] : acc_w[2*WIDTH-1:WIDTH];

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      rsign_d   = rsign_q;
      div0_d    = div0_q;
      is_div_d  = is_div_q;
      rs_d      = rs_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      iter_load = 1'b0;
      iter_step = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               // Captured for every accepted op; only mul/div consume them.
               sign_d   = sa_w ^ sb_w;
               rsign_d  = sa_w;
               div0_d   = rt_zero_w;
               is_div_d = op_div_w;
               rs_d     = rs_i;
               case (op_w)
                  OP_MULT, OP_MULTU: begin
                     iter_load = 1'b1;
                     state_d   = MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     iter_load = 1'b1;
                     state_d   = (DIV0_FAST && rt_zero_w) ? FIX : DIV;
                  end
                  OP_MTHI: begin
                     hi_d    = rs_i;
                     lo_d    = lo_cur_i;
                     state_d = WB;
                  end
                  OP_MTLO: begin
                     hi_d    = hi_cur_i;
                     lo_d    = rs_i;
                     state_d = WB;
                  end
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               iter_step = 1'b1;
               if (iter_last) state_d = FIX;
            end
         end
         FIX: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               if (!is_div_q) begin
                  hi_d = prod_fix_w[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix_w[WIDTH-1:0];
               end else if (div0_q) begin
                  hi_d = rs_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix_w;
                  lo_d = quot_fix_w;
               end
               state_d = WB;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         rsign_q  <= 1'b0;
         div0_q   <= 1'b0;
         is_div_q <= 1'b0;
         rs_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         rsign_q  <= rsign_d;
         div0_q   <= div0_d;
         is_div_q <= is_div_d;
         rs_q     <= rs_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // Decoded from the state register so reset takes effect immediately.
   assign busy_o    = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
   assign hilo_we_o = (state_q != WB);
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;

endmodule : hilo_muldiv_ctrl

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;
   import hilo_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = '0;
   logic [31:0] rs_i = '0, rt_i = '0, hi_cur_i = '0, lo_cur_i = '0;
   logic        flush_i = 1'b0;
   logic        busy_o, hilo_we_o;
   logic [31:0] hi_o, lo_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   hilo_muldiv_ctrl #(
      .WIDTH     (32),
      .DIV0_FAST (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .op_i      (op_i),
      .rs_i      (rs_i),
      .rt_i      (rt_i),
      .hi_cur_i  (hi_cur_i),
      .lo_cur_i  (lo_cur_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o),
      .hilo_we_o (hilo_we_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   // Reference model: plain 64-bit arithmetic, SV division truncates toward
   // zero and % takes the dividend's sign.
   function automatic void model(input logic [2:0] op, input logic [31:0] rs, rt, hc, lc,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] p;
      hi = '0;
      lo = '0;
      case (op)
         OP_MULT: begin
            sa = longint'($signed(rs));
            sb = longint'($signed(rt));
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
         end
         OP_MULTU: begin
            p  = {32'd0, rs} * {32'd0, rt};
            hi = p[63:32];
            lo = p[31:0];
         end
         OP_DIV: begin
            if (rt == 0) begin
               hi = rs;
               lo = 32'hFFFF_FFFF;
            end else begin
               sa = longint'($signed(rs));
               sb = longint'($signed(rt));
               q  = sa / sb;
               r  = sa % sb;
               hi = r[31:0];
               lo = q[31:0];
            end
         end
         OP_DIVU: begin
            if (rt == 0) begin
               hi = rs;
               lo = 32'hFFFF_FFFF;
            end else begin
               hi = rs % rt;
               lo = rs / rt;
            end
         end
         OP_MTHI: begin
            hi = rs;
            lo = lc;
         end
         OP_MTLO: begin
            hi = hc;
            lo = rs;
         end
         default: ;
      endcase
   endfunction

   // Cycle (counted from the accepting edge) in which the strobe appears.
   function automatic int latency(input logic [2:0] op, input logic [31:0] rt);
      if (op == OP_MTHI || op == OP_MTLO) return 1;
      if ((op == OP_DIV || op == OP_DIVU) && rt == 0) return 2;
      return 34;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op, check busy/strobe every cycle, data at the strobe and hold
   // afterwards. poke drives a stray start mid-operation that must be ignored.
   task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] rs, rt, hc, lc,
                        input bit poke);
      logic [31:0] exp_hi, exp_lo;
      logic        exp_busy, exp_we;
      int          lat;
      model(op, rs, rt, hc, lc, exp_hi, exp_lo);
      lat = latency(op, rt);
      @(negedge clk);
      start_i  = 1'b1;
      op_i     = op;
      rs_i     = rs;
      rt_i     = rt;
      hi_cur_i = hc;
      lo_cur_i = lc;
      @(negedge clk);
      start_i = 1'b0;
      if (lat > 1) begin
         // Operands must have been captured on acceptance.
         rs_i = $urandom;
         rt_i = $urandom;
      end
      for (int cyc = 1; cyc <= lat; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (poke && cyc == 5) begin
            start_i = 1'b1;
            op_i    = OP_MTHI;
         end
         if (poke && cyc == 6) start_i = 1'b0;
         exp_busy = (cyc < lat);
         exp_we   = (cyc != lat);
         vectors++;
         if (busy_o !== exp_busy || hilo_we_o !== exp_we) begin
            miscompares++;
            $display("FAIL %s ctl cyc=%0d busy=%b we=%b expected busy=%b we=%b",
                     name, cyc, busy_o, hilo_we_o, exp_busy, exp_we);
         end
         if (cyc == lat) begin
            vectors++;
            if (hi_o !== exp_hi || lo_o !== exp_lo) begin
               miscompares++;
               $display("FAIL %s data op=%0d rs=%h rt=%h hi=%h lo=%h expected hi=%h lo=%h",
                        name, op, rs, rt, hi_o, lo_o, exp_hi, exp_lo);
            end
         end
      end
      start_i = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy_o !== 1'b0 || hilo_we_o !== 1'b1 || hi_o !== exp_hi || lo_o !== exp_lo) begin
         miscompares++;
         $display("FAIL %s hold busy=%b we=%b hi=%h lo=%h expected 0 1 %h %h",
                  name, busy_o, hilo_we_o, hi_o, lo_o, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      vectors++;
      if ({busy_o, hilo_we_o, hi_o, lo_o} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
         miscompares++;
         $display("FAIL reset busy=%b we=%b hi=%h lo=%h expected 0 1 0 0",
                  busy_o, hilo_we_o, hi_o, lo_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      do_op("mult_neg",   OP_MULT,  32'hFFFF_FFFF, 32'h2, '0, '0, 1'b0);
      do_op("multu",      OP_MULTU, 32'hFFFF_FFFF, 32'h2, '0, '0, 1'b0);
      do_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h2, '0, '0, 1'b0);
      do_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, '0, '0, 1'b0);
      do_op("divu_zero",  OP_DIVU,  32'h7, 32'h0, '0, '0, 1'b0);
      do_op("div_zero",   OP_DIV,   32'hFFFF_FFF9, 32'h0, '0, '0, 1'b0);
      do_op("mthi",       OP_MTHI,  32'h1234, 32'h0, 32'h5555, 32'hABCD, 1'b0);
      do_op("mtlo",       OP_MTLO,  32'h4321, 32'h0, 32'h9876, 32'hABCD, 1'b0);
      do_op("mult_poked", OP_MULT,  32'h0000_1234, 32'hFFFF_FF00, '0, '0, 1'b1);
   endtask

   task automatic test_random();
      logic [2:0] op;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(1, 6));
         do_op("rand", op, pick_operand(), pick_operand(), $urandom, $urandom, (i % 4) == 0);
      end
   endtask

   task automatic test_ignored_ops();
      logic [31:0] h0, l0;
      h0 = hi_o;
      l0 = lo_o;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start_i = 1'b1;
         rs_i    = $urandom;
         flush_i = (k == 2);
         op_i    = (k == 0) ? 3'd0 : (k == 1) ? 3'd7 : OP_MTHI;
         @(negedge clk);
         start_i = 1'b0;
         flush_i = 1'b0;
         for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            vectors++;
            if (busy_o !== 1'b0 || hilo_we_o !== 1'b1 || hi_o !== h0 || lo_o !== l0) begin
               miscompares++;
               $display("FAIL ignored k=%0d busy=%b we=%b hi=%h lo=%h expected 0 1 %h %h",
                        k, busy_o, hilo_we_o, hi_o, lo_o, h0, l0);
            end
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] h0, l0;
      h0 = hi_o;
      l0 = lo_o;
      // Flush during DIV iteration, raised in cycle 10.
      @(negedge clk);
      start_i = 1'b1;
      op_i    = OP_DIV;
      rs_i    = 32'd1000;
      rt_i    = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (cyc > 1) @(negedge clk);
         vectors++;
         if (busy_o !== 1'b1 || hilo_we_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_div run cyc=%0d busy=%b we=%b expected 1 1", cyc, busy_o, hilo_we_o);
         end
      end
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      for (int cyc = 11; cyc <= 40; cyc++) begin
         if (cyc > 11) @(negedge clk);
         vectors++;
         if (busy_o !== 1'b0 || hilo_we_o !== 1'b1 || hi_o !== h0 || lo_o !== l0) begin
            miscompares++;
            $display("FAIL flush_div idle cyc=%0d busy=%b we=%b hi=%h lo=%h expected 0 1 %h %h",
                     cyc, busy_o, hilo_we_o, hi_o, lo_o, h0, l0);
         end
      end
      // Flush while in FIX (divide by zero takes the fast path).
      @(negedge clk);
      start_i = 1'b1;
      op_i    = OP_DIVU;
      rs_i    = 32'h77;
      rt_i    = 32'h0;
      @(negedge clk);
      start_i = 1'b0;
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         vectors++;
         if (busy_o !== 1'b0 || hilo_we_o !== 1'b1 || hi_o !== h0 || lo_o !== l0) begin
            miscompares++;
            $display("FAIL flush_fix c=%0d busy=%b we=%b hi=%h lo=%h expected 0 1 %h %h",
                     c, busy_o, hilo_we_o, hi_o, lo_o, h0, l0);
         end
      end
      // Flush during WB is ignored: the write still happens.
      @(negedge clk);
      start_i  = 1'b1;
      op_i     = OP_MTLO;
      rs_i     = 32'hCAFE_F00D;
      hi_cur_i = 32'h1111_2222;
      @(negedge clk);
      start_i = 1'b0;
      flush_i = 1'b1;
      vectors++;
      if (hilo_we_o !== 1'b0 || hi_o !== 32'h1111_2222 || lo_o !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL flush_wb we=%b hi=%h lo=%h expected 0 11112222 cafef00d", hilo_we_o, hi_o, lo_o);
      end
      @(negedge clk);
      flush_i = 1'b0;
      vectors++;
      if (hilo_we_o !== 1'b1 || busy_o !== 1'b0 || lo_o !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL flush_wb_after we=%b busy=%b lo=%h expected 1 0 cafef00d", hilo_we_o, busy_o, lo_o);
      end
   endtask

   task automatic test_reset_mid_mul();
      do_op("pre_reset", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 1'b0);
      @(negedge clk);
      start_i = 1'b1;
      op_i    = OP_MULT;
      rs_i    = 32'h1357_9BDF;
      rt_i    = 32'h0246_8ACE;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      vectors++;
      if (busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid busy_before=%b expected 1", busy_o);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({busy_o, hilo_we_o, hi_o, lo_o} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
         miscompares++;
         $display("FAIL reset_mid async busy=%b we=%b hi=%h lo=%h expected 0 1 0 0",
                  busy_o, hilo_we_o, hi_o, lo_o);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy_o, hilo_we_o, hi_o, lo_o} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
         miscompares++;
         $display("FAIL reset_mid after busy=%b we=%b hi=%h lo=%h expected 0 1 0 0",
                  busy_o, hilo_we_o, hi_o, lo_o);
      end
      do_op("post_reset", OP_DIVU, 32'd100, 32'd9, '0, '0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignored_ops();
      test_flush();
      test_reset_mid_mul();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_hilo_muldiv_ctrl
